bnn_io_ctrl: RTL and testbench
==============================

Name: bnn_io_ctrl

Overview:
Front-end sequencer for the BNN accelerator top. It owns the shared pin interface: mode, valid/ready, the 16-bit input beat whose low nibble sits on the bidirectional pad, and out_en. It steers accepted beats either into the 96-bit weight register (mode=1) or to the compute core as pixel beats (mode=0). It also schedules bus turnaround so result nibbles from the core are driven back out on the 4-bit pad.

Parameters:
W_BEATS, 6, beats per weight load
BEAT_W, 16, input beat width
RES_W, 4, result nibble width (pad width)
FIFO_DEPTH, 4, result FIFO entries (power of 2)
TURN_CYC, 1, idle cycles at each bus direction change

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mode  in  1  1=weight load, 0=data stream
in_valid  in  1  pin-side beat valid
in_ready  out  1  pin-side beat accepted when in_valid&in_ready
beat_in  in  BEAT_W  assembled beat {data_in_port, pad_in}
weight_out  out  W_BEATS*BEAT_W  weight register
weight_load  out  1  1-cycle pulse, weight_out updated
pix_valid  out  1  beat to core
pix_ready  in  1  core accepts beat
pix_data  out  BEAT_W  beat payload
res_valid  in  1  result from core
res_ready  out  1  FIFO not full
res_data  in  RES_W  result nibble
out_en  out  1  1=controller drives pad
pad_out  out  RES_W  pad drive value
err  out  1  sticky protocol error

Behaviour:
- Reset (async, immediate): state=IDLE, in_ready=0, out_en=0, pad_out=0, pix_valid=0, weight_load=0, weight_out=0, err=0, FIFO empty, counters 0. out_en drops the moment rst asserts (bus safety).
- States: IDLE, WLOAD, WDONE, STREAM, TURN_OUT, DRIVE, TURN_IN.
- in_ready (combinational) = state in {IDLE,WLOAD,STREAM} & !(fifo_nonempty & state!=WLOAD) & (mode | !pix_valid | pix_ready).
- IDLE: accept with mode=1 -> store beat 0, beat_cnt=1, go to WLOAD. Accept with mode=0 -> register pix, go to STREAM. If FIFO is non-empty -> TURN_OUT. The result check has priority over a simultaneous in_valid because in_ready is already low.
- WLOAD: beat k lands at weight_out[16k+15:16k]. On beat W_BEATS-1 -> WDONE. mode is ignored except as follows: an accept with mode=0 mid-load sets err, discards the partial load (weight_out unchanged), and goes to IDLE. WLOAD is never interrupted by results; the FIFO fills and res_ready throttles the core.
- WDONE: weight_load=1 for exactly 1 cycle, in_ready=0, then IDLE.
- STREAM: each accept registers pix_data and sets pix_valid the next cycle (latency 1). pix_valid holds until pix_ready. An accept with mode=1 ends the stream; that beat becomes weight beat 0 and the state goes to WLOAD. If there is no accept and pix_valid is clear, go to IDLE. If FIFO is non-empty and pix_valid is clear, go to TURN_OUT.
- TURN_OUT: TURN_CYC cycles with out_en=0 and in_ready=0, then DRIVE.
- DRIVE: out_en=1, pad_out=FIFO head, one pop per cycle. A result pushed during DRIVE is driven in the same burst. When the FIFO goes empty, out_en=0 on the next cycle and the state goes to TURN_IN.
- TURN_IN: TURN_CYC cycles with in_ready=0, then IDLE.
- FIFO: simultaneous push and pop is allowed when full. A push while full is impossible (res_ready=0).

Optional Feature:
BNN_IO_WCHK_EN
- Defined: a weight load is W_BEATS+1 beats. The last beat must equal the XOR of the W_BEATS data beats. On mismatch: set err, suppress weight_load, leave weight_out unchanged.
- Undefined: W_BEATS beats, no check.

Decomposition:
- bnn_io_pkg: state enum, W_BEATS, BEAT_W, RES_W, WREG_W=W_BEATS*BEAT_W.
- Sub-module bnn_res_fifo: synchronous FIFO, depth FIFO_DEPTH, with full/empty flags.

Test Plan:
- Reset, then 6 mode=1 beats 0x1111..0x6666 -> weight_out=0x666655554444333322221111, one weight_load pulse, in_ready low 1 cycle.
- Stream 150 beats (nibbles (i+j)%16) with pix_ready toggled 1-in-3 -> 150 pix beats delivered in order, none duplicated or dropped.
- Push results 0xA,0xB,0xC while streaming -> in_ready falls, 1 dead cycle, out_en high 3 cycles with pad_out A,B,C, 1 dead cycle, in_ready returns.
- 5 results pushed during WLOAD -> res_ready low after 4, load completes, DRIVE outputs all 5 in order.
- mode=0 accept at beat 3 of a weight load -> err=1, no weight_load, weight_out unchanged. Assert rst during DRIVE -> out_en=0 in the same cycle.
- BNN_IO_WCHK_EN defined, wrong check beat -> err=1, no weight_load. Correct check beat -> weight_load pulse.

Source files
------------

// File: rtl/bnn_io_pkg.sv
// rtl/bnn_io_pkg.sv - shared sizes and state encoding for the BNN I/O sequencer
package bnn_io_pkg;

    localparam int W_BEATS    = 6;
    localparam int BEAT_W     = 16;
    localparam int RES_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TURN_CYC   = 1;
    localparam int WREG_W     = W_BEATS * BEAT_W;
    localparam int CNT_W      = $clog2(W_BEATS + 1);
    localparam int TURN_W     = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WDONE,
        STREAM,
        TURN_OUT,
        DRIVE,
        TURN_IN
    } state_t;

endpackage

// File: rtl/bnn_res_fifo.sv
// rtl/bnn_res_fifo.sv - result nibble FIFO with full/empty flags, head visible combinationally
module bnn_res_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bnn_io_ctrl.sv
// rtl/bnn_io_ctrl.sv - BNN front-end pin sequencer: weight load, pixel stream, pad turnaround
// BNN_IO_WCHK_EN: weight load takes an extra XOR check beat before committing.
module bnn_io_ctrl
    import bnn_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [WREG_W-1:0] weight_out,
    output logic              weight_load,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [BEAT_W-1:0] pix_data,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [RES_W-1:0]  res_data,
    output logic              out_en,
    output logic [RES_W-1:0]  pad_out,
    output logic              err
);

`ifdef BNN_IO_WCHK_EN
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(W_BEATS);
    logic [BEAT_W-1:0] wxor;
`else
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(W_BEATS - 1);
`endif

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [WREG_W-1:0] wbuf;
    logic [WREG_W-1:0] wnext;
    logic [TURN_W-1:0] turn_cnt;
    logic [RES_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              accept;
    logic              turn_done;
    logic              start_load;
    logic              pix_room;

    assign res_ready  = ~fifo_full;
    assign accept     = in_valid & in_ready;
    assign turn_done  = (turn_cnt == TURN_W'(TURN_CYC - 1));
    assign start_load = accept & mode & ((state == IDLE) | (state == STREAM));
    assign pix_room   = mode | ~pix_valid | pix_ready;
    assign pop        = ~fifo_empty & (((state == TURN_OUT) & turn_done) | (state == DRIVE));

    // Pending results block new beats except mid weight load, which must finish first.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE, STREAM: in_ready = ~rst & fifo_empty & pix_room;
            WLOAD:        in_ready = ~rst & pix_room;
            default:      in_ready = 1'b0;
        endcase
    end

    always_comb begin
        wnext = wbuf;
        for (int k = 0; k < W_BEATS; k++) begin
            if (beat_cnt == CNT_W'(k)) wnext[k*BEAT_W +: BEAT_W] = beat_in;
        end
    end

    bnn_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid & res_ready),
        .push_data (res_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            wbuf        <= '0;
            weight_out  <= '0;
            weight_load <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            out_en      <= 1'b0;
            pad_out     <= '0;
            err         <= 1'b0;
            turn_cnt    <= '0;
`ifdef BNN_IO_WCHK_EN
            wxor        <= '0;
`endif
        end else begin
            weight_load <= 1'b0;

            if (accept && !mode && state != WLOAD) begin
                pix_data  <= beat_in;
                pix_valid <= 1'b1;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end

            // Staging buffer keeps weight_out intact until the whole load is accepted.
            if (start_load) begin
                wbuf[BEAT_W-1:0] <= beat_in;
                beat_cnt         <= CNT_W'(1);
`ifdef BNN_IO_WCHK_EN
                wxor             <= beat_in;
`endif
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= TURN_OUT;
                        turn_cnt <= '0;
                    end else if (accept) begin
                        state <= mode ? WLOAD : STREAM;
                    end
                end
                WLOAD: begin
                    if (accept) begin
                        if (!mode) begin
                            err      <= 1'b1;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
`ifdef BNN_IO_WCHK_EN
                            if (beat_in == wxor) begin
                                weight_out  <= wbuf;
                                weight_load <= 1'b1;
                                state       <= WDONE;
                            end else begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end
`else
                            weight_out  <= wnext;
                            weight_load <= 1'b1;
                            state       <= WDONE;
`endif
                        end else begin
                            wbuf     <= wnext;
                            beat_cnt <= beat_cnt + CNT_W'(1);
`ifdef BNN_IO_WCHK_EN
                            wxor     <= wxor ^ beat_in;
`endif
                        end
                    end
                end
                WDONE: state <= IDLE;
                STREAM: begin
                    if (accept && mode) begin
                        state <= WLOAD;
                    end else if (!accept && !pix_valid) begin
                        if (!fifo_empty) begin
                            state    <= TURN_OUT;
                            turn_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                TURN_OUT: begin
                    if (turn_done) begin
                        state   <= DRIVE;
                        out_en  <= 1'b1;
                        pad_out <= fifo_head;
                    end else begin
                        turn_cnt <= turn_cnt + TURN_W'(1);
                    end
                end
                DRIVE: begin
                    if (!fifo_empty) begin
                        out_en  <= 1'b1;
                        pad_out <= fifo_head;
                    end else begin
                        out_en   <= 1'b0;
                        pad_out  <= '0;
                        turn_cnt <= '0;
                        state    <= TURN_IN;
                    end
                end
                TURN_IN: begin
                    if (turn_done) state <= IDLE;
                    else           turn_cnt <= turn_cnt + TURN_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_io_ctrl.sv
// tb/tb_bnn_io_ctrl.sv - directed self-checking bench for bnn_io_ctrl
module tb_bnn_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] beat_in;
    logic [95:0] weight_out;
    logic        weight_load;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic        out_en;
    logic [3:0]  pad_out;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wl_pulses = 0;
    logic        throttle = 1'b0;
    logic [15:0] pix_q[$];
    logic [3:0]  pad_q[$];

    bnn_io_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .beat_in     (beat_in),
        .weight_out  (weight_out),
        .weight_load (weight_load),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .out_en      (out_en),
        .pad_out     (pad_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        pix_ready = throttle ? (cyc % 3 == 0) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (pix_valid && pix_ready) pix_q.push_back(pix_data);
            if (out_en) pad_q.push_back(pad_out);
            if (weight_load) wl_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d, required finish before", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [15:0] d);
        int c;
        mode = m; beat_in = d; in_valid = 1'b1;
        #1;
        c = 0;
        while (!in_ready && c < 200) begin
            @(posedge clk); #2; c++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL send_accept in_ready=%0b required 1 beat=%h", in_ready, d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] pix_word(input int i);
        logic [15:0] v;
        for (int j = 0; j < 4; j++) v[j*4 +: 4] = 4'((i + j) % 16);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b required 0", in_ready); end
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %0b required 0", out_en); end
        checks++; if (pad_out !== 4'h0) begin errors++; $display("FAIL reset_pad_out got %h required 0", pad_out); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %0b required 0", pix_valid); end
        checks++; if (weight_load !== 1'b0) begin errors++; $display("FAIL reset_weight_load got %0b required 0", weight_load); end
        checks++; if (weight_out !== 96'h0) begin errors++; $display("FAIL reset_weight_out got %h required 0", weight_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b required 0", err); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got %0b required 1", res_ready); end
        step();
        rst = 1'b0;
        step(); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b required 1", in_ready); end
    endtask

    task automatic test_weight_load();
        logic [95:0] w;
        int p0;
        w = 96'h666655554444333322221111;
        p0 = wl_pulses;
        for (int k = 0; k < 6; k++) send(1'b1, w[k*16 +: 16]);
`ifdef BNN_IO_WCHK_EN
        send(1'b1, 16'h7777);
`endif
        #1;
        checks++; if (weight_load !== 1'b1) begin errors++; $display("FAIL wload_pulse got %0b required 1", weight_load); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wdone_in_ready got %0b required 0", in_ready); end
        checks++; if (weight_out !== w) begin errors++; $display("FAIL wload_value got %h required %h", weight_out, w); end
        step(); #1;
        checks++; if (weight_load !== 1'b0) begin errors++; $display("FAIL wload_pulse_end got %0b required 0", weight_load); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wload_in_ready_back got %0b required 1", in_ready); end
        checks++; if (wl_pulses - p0 !== 1) begin errors++; $display("FAIL wload_pulse_count got %0d required 1", wl_pulses - p0); end
    endtask

    task automatic test_stream();
        int c;
        pix_q.delete();
        throttle = 1'b1;
        for (int i = 0; i < 150; i++) send(1'b0, pix_word(i));
        c = 0;
        while (pix_q.size() < 150 && c < 1000) begin step(); c++; end
        throttle = 1'b0;
        repeat (3) step();
        checks++; if (pix_q.size() !== 150) begin errors++; $display("FAIL stream_count got %0d required 150", pix_q.size()); end
        for (int i = 0; i < 150 && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== pix_word(i)) begin
                errors++; $display("FAIL stream_beat_%0d got %h required %h", i, pix_q[i], pix_word(i));
            end
        end
    endtask

    task automatic test_result_turnaround();
        logic       exp_ir  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic       exp_oe  [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        logic [3:0] exp_pad [8] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'h0, 4'h0};
        send(1'b0, 16'h1234);
        in_valid = 1'b1; mode = 1'b0; beat_in = 16'h5678;
        res_valid = 1'b1; res_data = 4'hA;
        for (int t = 0; t < 8; t++) begin
            step();
            if (t == 0) res_data = 4'hB;
            if (t == 1) res_data = 4'hC;
            if (t == 2) res_valid = 1'b0;
            #1;
            checks++; if (in_ready !== exp_ir[t]) begin errors++; $display("FAIL turn_in_ready_t%0d got %0b required %0b", t, in_ready, exp_ir[t]); end
            checks++; if (out_en !== exp_oe[t]) begin errors++; $display("FAIL turn_out_en_t%0d got %0b required %0b", t, out_en, exp_oe[t]); end
            checks++; if (pad_out !== exp_pad[t]) begin errors++; $display("FAIL turn_pad_t%0d got %h required %h", t, pad_out, exp_pad[t]); end
        end
        in_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_wload_results();
        logic [3:0]  r [5] = '{4'h3, 4'h7, 4'hE, 4'h1, 4'h9};
        logic [95:0] w2;
        logic [15:0] x;
        logic        pushed;
        int          c;
        x = 16'h0;
        for (int k = 0; k < 6; k++) begin
            w2[k*16 +: 16] = 16'hC000 | 16'(k * 16'h0111);
            x = x ^ w2[k*16 +: 16];
        end
        pad_q.delete();
        send(1'b1, w2[15:0]);
        for (int j = 0; j < 4; j++) begin
            res_valid = 1'b1; res_data = r[j];
            step();
        end
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL wload_res_ready_full got %0b required 0", res_ready); end
        res_data = r[4];
        for (int k = 1; k < 6; k++) send(1'b1, w2[k*16 +: 16]);
`ifdef BNN_IO_WCHK_EN
        send(1'b1, x);
`endif
        c = 0;
        while (pad_q.size() < 5 && c < 100) begin
            #1;
            pushed = res_valid && res_ready;
            step();
            if (pushed) res_valid = 1'b0;
            c++;
        end
        res_valid = 1'b0;
        repeat (4) step();
        checks++; if (weight_out !== w2) begin errors++; $display("FAIL wload_res_weight got %h required %h", weight_out, w2); end
        checks++; if (pad_q.size() !== 5) begin errors++; $display("FAIL wload_res_count got %0d required 5", pad_q.size()); end
        for (int j = 0; j < 5 && j < pad_q.size(); j++) begin
            checks++;
            if (pad_q[j] !== r[j]) begin errors++; $display("FAIL wload_res_%0d got %h required %h", j, pad_q[j], r[j]); end
        end
    endtask

    task automatic test_abort();
        logic [95:0] wsnap;
        int          p0;
        wsnap = weight_out;
        p0 = wl_pulses;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_before got %0b required 0", err); end
        send(1'b1, 16'hBEEF);
        send(1'b1, 16'hCAFE);
        send(1'b1, 16'hF00D);
        send(1'b0, 16'hDEAD);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err got %0b required 1", err); end
        repeat (8) step();
        checks++; if (weight_out !== wsnap) begin errors++; $display("FAIL abort_weight got %h required %h", weight_out, wsnap); end
        checks++; if (wl_pulses - p0 !== 0) begin errors++; $display("FAIL abort_pulses got %0d required 0", wl_pulses - p0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %0b required 1", in_ready); end
    endtask

    task automatic test_reset_in_drive();
        int c;
        for (int j = 0; j < 3; j++) begin
            res_valid = 1'b1; res_data = 4'(j + 5);
            step();
        end
        res_valid = 1'b0;
        c = 0;
        #1;
        while (!out_en && c < 50) begin step(); #1; c++; end
        checks++; if (out_en !== 1'b1) begin errors++; $display("FAIL drive_reached out_en=%0b required 1", out_en); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL rst_drive_out_en got %0b required 0", out_en); end
        checks++; if (pad_out !== 4'h0) begin errors++; $display("FAIL rst_drive_pad got %h required 0", pad_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_drive_err got %0b required 0", err); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rst_drive_res_ready got %0b required 1", res_ready); end
        step();
        rst = 1'b0;
        repeat (2) step();
    endtask

`ifdef BNN_IO_WCHK_EN
    task automatic test_wchk();
        logic [95:0] w3;
        logic [95:0] wsnap;
        logic [15:0] x;
        int          p0;
        x = 16'h0;
        for (int k = 0; k < 6; k++) begin
            w3[k*16 +: 16] = 16'h1357 + 16'(k * 16'h2222);
            x = x ^ w3[k*16 +: 16];
        end
        wsnap = weight_out;
        p0 = wl_pulses;
        for (int k = 0; k < 6; k++) send(1'b1, w3[k*16 +: 16]);
        send(1'b1, x ^ 16'h0001);
        repeat (3) step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wchk_bad_err got %0b required 1", err); end
        checks++; if (wl_pulses - p0 !== 0) begin errors++; $display("FAIL wchk_bad_pulses got %0d required 0", wl_pulses - p0); end
        checks++; if (weight_out !== wsnap) begin errors++; $display("FAIL wchk_bad_weight got %h required %h", weight_out, wsnap); end
        rst = 1'b1; step(); rst = 1'b0; step();
        p0 = wl_pulses;
        for (int k = 0; k < 6; k++) send(1'b1, w3[k*16 +: 16]);
        send(1'b1, x);
        repeat (3) step();
        checks++; if (wl_pulses - p0 !== 1) begin errors++; $display("FAIL wchk_good_pulses got %0d required 1", wl_pulses - p0); end
        checks++; if (weight_out !== w3) begin errors++; $display("FAIL wchk_good_weight got %h required %h", weight_out, w3); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wchk_good_err got %0b required 0", err); end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; beat_in = 16'h0;
        res_valid = 1'b0; res_data = 4'h0;
        test_reset();
        test_weight_load();
        test_stream();
        test_result_turnaround();
        test_wload_results();
        test_abort();
        test_reset_in_drive();
`ifdef BNN_IO_WCHK_EN
        test_wchk();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
